// File: rtl/im_loader.sv
// im_loader: loads a byte stream (16-bit big-endian word count followed by
// big-endian instruction words) into instruction memory via a write strobe.
// Optional macro IM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module im_loader #(
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [10:0] word_count
);

   localparam int unsigned LEN_W = 16;
   localparam int unsigned WC_W  = 11;

`ifdef IM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [23:0]       shreg_q, shreg_d;
   logic [WC_W-1:0]   wc_q, wc_d;
   logic              wr_en_q, wr_en_d;
   logic [31:0]       wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              byte_ready_q, byte_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              accept;
   logic [LEN_W-1:0]  n_len;
`ifdef IM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      bcnt_d    = bcnt_q;
      shreg_d   = shreg_q;
      wc_d      = wc_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      accept    = byte_valid & byte_ready_q;
      n_len     = {len_q[15:8], byte_data};

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN_HI;
               wc_d    = '0;
               bcnt_d  = '0;
`ifdef IM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d   = {byte_data, 8'h00};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d = n_len;
               if ((n_len == 16'd0) || (32'(n_len) > 32'(MAX_WORDS)))
                  state_d = S_ERR;
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
`ifdef IM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byte_data;
`endif
               if (bcnt_q == 2'd3) begin
                  // Fourth byte completes a word; next byte may follow immediately
                  wr_data_d = {shreg_q, byte_data};
                  wr_addr_d = BASE_ADDR + (32'(wc_q) << 2);
                  wr_en_d   = 1'b1;
                  wc_d      = wc_q + 11'd1;
                  bcnt_d    = 2'd0;
                  if ((16'(wc_q) + 16'd1) == len_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
                     state_d = S_CSUM;
`else
                     state_d = S_DONE;
`endif
                  end
               end else begin
                  shreg_d = {shreg_q[15:0], byte_data};
                  bcnt_d  = bcnt_q + 2'd1;
               end
            end
         end
`ifdef IM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept)
               state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
`ifdef IM_LOADER_CHECKSUM_EN
                     (state_d == S_CSUM) ||
`endif
                     (state_d == S_DATA);
      busy_d  = byte_ready_d;
      done_d  = (state_d == S_DONE);
      error_d = (state_d == S_ERR);
   end

   // State and output registers; reset discards any partial word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         bcnt_q       <= '0;
         shreg_q      <= '0;
         wc_q         <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         bcnt_q       <= bcnt_d;
         shreg_q      <= shreg_d;
         wc_q         <= wc_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         byte_ready_q <= byte_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
`ifdef IM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign byte_ready = byte_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: two instances (base 0 and base 0x3000) share stimulus;
// a stream-level model predicts every output each cycle.
module tb_im_loader;

   localparam logic [31:0] BASE_A = 32'h0000_0000;
   localparam logic [31:0] BASE_B = 32'h0000_3000;
   localparam int unsigned MAXW   = 1024;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;

   logic a_ready, a_wen, a_busy, a_done, a_err;
   logic [31:0] a_addr, a_data;
   logic [10:0] a_wc;
   logic b_ready, b_wen, b_busy, b_done, b_err;
   logic [31:0] b_addr, b_data;
   logic [10:0] b_wc;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic [31:0] la_addr[$], la_data[$], lb_addr[$];
   logic [7:0]  stream[$];

   im_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE_A)) dut_a (
      .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(a_ready), .wr_en(a_wen),
      .wr_addr(a_addr), .wr_data(a_data), .busy(a_busy), .done(a_done),
      .error(a_err), .word_count(a_wc));

   im_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE_B)) dut_b (
      .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(b_ready), .wr_en(b_wen),
      .wr_addr(b_addr), .wr_data(b_data), .busy(b_busy), .done(b_done),
      .error(b_err), .word_count(b_wc));

   always #5 clk = ~clk;

   // Stream-level model: counts bytes since start and derives every output
   bit          m_act[2], m_done[2], m_err[2], m_wen[2];
   int unsigned m_nb[2], m_n[2], m_wc[2];
   logic [31:0] m_word[2], m_addr[2], m_data[2];
   logic [7:0]  m_x[2];

   always @(posedge clk or negedge reset) begin : model
      int unsigned d;
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            m_act[i] = 0; m_done[i] = 0; m_err[i] = 0; m_wen[i] = 0;
            m_nb[i] = 0; m_n[i] = 0; m_wc[i] = 0;
            m_word[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_x[i] = 0;
         end else begin
            m_wen[i] = 0;
            if (m_act[i] && byte_valid) begin
               if (m_nb[i] == 0) begin
                  m_n[i] = 256 * int'(byte_data);
               end else if (m_nb[i] == 1) begin
                  m_n[i] = m_n[i] + int'(byte_data);
                  if (m_n[i] == 0 || m_n[i] > MAXW) begin
                     m_act[i] = 0; m_err[i] = 1;
                  end
               end else begin
                  d = m_nb[i] - 2;
                  if (d < 4 * m_n[i]) begin
                     m_word[i] = {m_word[i][23:0], byte_data};
                     m_x[i] = m_x[i] ^ byte_data;
                     if (d % 4 == 3) begin
                        m_wen[i]  = 1;
                        m_addr[i] = ((i == 0) ? BASE_A : BASE_B) + 4 * (d / 4);
                        m_data[i] = m_word[i];
                        m_wc[i]   = m_wc[i] + 1;
`ifndef IM_LOADER_CHECKSUM_EN
                        if (d == 4 * m_n[i] - 1) begin
                           m_act[i] = 0; m_done[i] = 1;
                        end
`endif
                     end
                  end else begin
                     if (byte_data == m_x[i]) m_done[i] = 1;
                     else m_err[i] = 1;
                     m_act[i] = 0;
                  end
               end
               m_nb[i] = m_nb[i] + 1;
            end else if (start && !m_act[i]) begin
               m_act[i] = 1; m_nb[i] = 0; m_done[i] = 0; m_err[i] = 0;
               m_wc[i] = 0; m_x[i] = 0; m_word[i] = 0;
            end
         end
      end
   end

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endfunction

   // Per-cycle comparison against the model, and write logging
   always @(negedge clk) begin
      if (chk_en) begin
         chk("a.byte_ready", 32'(a_ready), 32'(m_act[0]));
         chk("a.busy",       32'(a_busy),  32'(m_act[0]));
         chk("a.done",       32'(a_done),  32'(m_done[0]));
         chk("a.error",      32'(a_err),   32'(m_err[0]));
         chk("a.word_count", 32'(a_wc),    m_wc[0]);
         chk("a.wr_en",      32'(a_wen),   32'(m_wen[0]));
         chk("a.wr_addr",    a_addr,       m_addr[0]);
         chk("a.wr_data",    a_data,       m_data[0]);
         chk("b.byte_ready", 32'(b_ready), 32'(m_act[1]));
         chk("b.done",       32'(b_done),  32'(m_done[1]));
         chk("b.error",      32'(b_err),   32'(m_err[1]));
         chk("b.word_count", 32'(b_wc),    m_wc[1]);
         chk("b.wr_en",      32'(b_wen),   32'(m_wen[1]));
         chk("b.wr_addr",    b_addr,       m_addr[1]);
         chk("b.wr_data",    b_data,       m_data[1]);
      end
      if (a_wen) begin la_addr.push_back(a_addr); la_data.push_back(a_data); end
      if (b_wen) lb_addr.push_back(b_addr);
   end

   task automatic pulse_start();
      @(negedge clk); byte_valid = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); byte_valid = 1'b0; start = 1'b0;
      end
   endtask

   // Present one byte until the loader takes it; optional random gaps
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit sent = 1'b0;
      for (int i = 0; i < 64 && !sent; i++) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 1) == 0) begin
            byte_valid = 1'b0;
         end else begin
            byte_valid = 1'b1; byte_data = b; sent = a_ready;
         end
      end
      if (!sent) begin
         tests++; fails++;
         $display("FAIL send_byte timeout byte %h ready %b", b, a_ready);
      end
   endtask

   task automatic send_stream(input bit gaps, input int start_at);
      for (int i = 0; i < stream.size(); i++) begin
         if (i == start_at) pulse_start();
         send_byte(stream[i], gaps);
      end
      idle(2);
   endtask

   task automatic add_csum();
`ifdef IM_LOADER_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
      stream.push_back(x);
`endif
   endtask

   int w0;
   logic [31:0] ref_addr[$], ref_data[$];

   initial begin
      idle(3);
      chk_en = 1'b1;
      idle(1);
      chk("reset.wr_data", a_data, 32'h0);
      chk("reset.word_count", 32'(a_wc), 32'h0);
      reset = 1'b1;

      // Bytes offered before any start must be ignored
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); byte_valid = 1'b1; byte_data = 8'h55;
      end
      idle(1);
      chk("nostart.busy", 32'(a_busy), 32'h0);
      chk("nostart.writes", 32'(la_addr.size()), 32'h0);

      // Two-word program, gap-free
      stream = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      add_csum();
      pulse_start();
      send_stream(1'b0, -1);
      chk("basic.nwrites", 32'(la_addr.size()), 32'd2);
      chk("basic.addr0", la_addr[0], 32'h0000_0000);
      chk("basic.data0", la_data[0], 32'h2408_0005);
      chk("basic.addr1", la_addr[1], 32'h0000_0004);
      chk("basic.data1", la_data[1], 32'hAC08_0000);
      chk("basic.done", 32'(a_done), 32'h1);
      chk("basic.word_count", 32'(a_wc), 32'd2);
      ref_addr = la_addr; ref_data = la_data;

      // Bad lengths: zero and MAX_WORDS+1
      w0 = la_addr.size();
      stream = '{8'h00, 8'h00};
      pulse_start(); send_stream(1'b0, -1);
      chk("len0.error", 32'(a_err), 32'h1);
      stream = '{8'h04, 8'h01};
      pulse_start(); send_stream(1'b0, -1);
      chk("len1025.error", 32'(a_err), 32'h1);
      chk("badlen.nwrites", 32'(la_addr.size() - w0), 32'h0);

      // Reset after 6 of 8 data bytes
      w0 = la_addr.size();
      stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      pulse_start(); send_stream(1'b0, -1);
      @(negedge clk); #1 reset = 1'b0;
      idle(2);
      chk("rst.nwrites", 32'(la_addr.size() - w0), 32'd1);
      chk("rst.wr_addr", a_addr, 32'h0);
      chk("rst.busy", 32'(a_busy), 32'h0);
      reset = 1'b1;
      idle(1);
      stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      add_csum();
      pulse_start(); send_stream(1'b0, -1);
      chk("rst.restart_done", 32'(a_done), 32'h1);

      // Gappy valid with a mid-load start pulse must reproduce the first load
      w0 = la_addr.size();
      stream = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      add_csum();
      pulse_start(); send_stream(1'b1, 5);
      chk("gap.nwrites", 32'(la_addr.size() - w0), 32'd2);
      for (int i = 0; i < 2; i++) begin
         chk("gap.addr", la_addr[w0 + i], ref_addr[i]);
         chk("gap.data", la_data[w0 + i], ref_data[i]);
      end
      chk("gap.done", 32'(a_done), 32'h1);

      // Three words on the offset-base instance
      w0 = lb_addr.size();
      stream = '{8'h00, 8'h03};
      for (int i = 0; i < 12; i++) stream.push_back(8'(i + 1));
      add_csum();
      pulse_start(); send_stream(1'b0, -1);
      chk("base.addr0", lb_addr[w0],     32'h0000_3000);
      chk("base.addr1", lb_addr[w0 + 1], 32'h0000_3004);
      chk("base.addr2", lb_addr[w0 + 2], 32'h0000_3008);

      // Largest legal load
      stream = '{8'h04, 8'h00};
      for (int i = 0; i < 4 * MAXW; i++) stream.push_back(8'h00);
      add_csum();
      pulse_start(); send_stream(1'b0, -1);
      chk("max.done", 32'(a_done), 32'h1);
      chk("max.word_count", 32'(a_wc), 32'd1024);
      chk("max.last_addr", a_addr, 32'h0000_0FFC);

`ifdef IM_LOADER_CHECKSUM_EN
      stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
      pulse_start(); send_stream(1'b0, -1);
      chk("csum.good_done", 32'(a_done), 32'h1);
      w0 = la_addr.size();
      stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      pulse_start(); send_stream(1'b0, -1);
      chk("csum.bad_error", 32'(a_err), 32'h1);
      chk("csum.bad_nwrites", 32'(la_addr.size() - w0), 32'd1);
      chk("csum.bad_addr", la_addr[w0], 32'h0000_0000);
      chk("csum.bad_data", la_data[w0], 32'h1234_5678);
`endif

      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
